// File: rtl/memtest_seq.sv
// Pass sequencer for the memory tester: drives the LFSR generator strobes and
// runs write-then-verify passes over [0, len) through a single-outstanding port.
module memtest_seq #(
   parameter int ADDR_W = 24,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic [ADDR_W-1:0] len,
   input  logic [7:0]        seed,
   input  logic [DATA_W-1:0] rnd_in,
   output logic              rnd_init,
   output logic              rnd_save,
   output logic              rnd_restore,
   output logic              rnd_next,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic [15:0]       pass_cnt,
   output logic [15:0]       err_cnt,
   output logic              err,
   output logic [ADDR_W-1:0] fail_addr
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_INIT    = 3'd1;
   localparam logic [2:0] S_SAVE    = 3'd2;
   localparam logic [2:0] S_WR      = 3'd3;
   localparam logic [2:0] S_WSTEP   = 3'd4;
   localparam logic [2:0] S_RESTORE = 3'd5;
   localparam logic [2:0] S_RD      = 3'd6;
   localparam logic [2:0] S_RSTEP   = 3'd7;

   localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

   logic [2:0]        state;
   logic [2:0]        state_nx;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] len_q;
   logic [7:0]        seed_q;
   logic [7:0]        init_cnt;
   logic              abort_q;
   logic              abort_now;
   logic              last_word;
   logic              start_ok;
   logic              rd_miss;

   // A stop arriving this cycle is honoured at once, same as a latched one.
   assign abort_now = abort_q | stop;
   assign last_word = (addr == (len_q - ADDR_ONE));
   assign start_ok  = (state == S_IDLE) && start && (len != '0);
   assign rd_miss   = (state == S_RD) && mem_ack && (mem_rdata != rnd_in);

   // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:    if (start_ok) state_nx = S_INIT;
         S_INIT:    if (abort_now) state_nx = S_IDLE;
                    else if (init_cnt == seed_q) state_nx = S_SAVE;
         S_SAVE:    state_nx = abort_now ? S_IDLE : S_WR;
         S_WR:      if (mem_ack) state_nx = abort_now ? S_IDLE : S_WSTEP;
         S_WSTEP:   if (abort_now) state_nx = S_IDLE;
                    else state_nx = last_word ? S_RESTORE : S_WR;
         S_RESTORE: state_nx = abort_now ? S_IDLE : S_RD;
         S_RD:      if (mem_ack) state_nx = abort_now ? S_IDLE : S_RSTEP;
         S_RSTEP:   if (abort_now) state_nx = S_IDLE;
                    else state_nx = last_word ? S_SAVE : S_RD;
         default:   state_nx = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         addr      <= '0;
         len_q     <= '0;
         seed_q    <= '0;
         init_cnt  <= '0;
         abort_q   <= 1'b0;
         pass_cnt  <= '0;
         err_cnt   <= '0;
         err       <= 1'b0;
         fail_addr <= '0;
      end else begin
         state <= state_nx;

         if (state_nx == S_IDLE)
            abort_q <= 1'b0;
         else if (stop && state != S_IDLE)
            abort_q <= 1'b1;

         if (start_ok) begin
            len_q     <= len;
            seed_q    <= seed;
            init_cnt  <= '0;
            addr      <= '0;
            pass_cnt  <= '0;
            err_cnt   <= '0;
            err       <= 1'b0;
            fail_addr <= '0;
         end

         if (state == S_INIT)
            init_cnt <= init_cnt + 8'd1;

         if (state == S_SAVE || state == S_RESTORE)
            addr <= '0;
         else if (state == S_WSTEP || state == S_RSTEP)
            addr <= addr + ADDR_ONE;

         if (state == S_RSTEP && last_word && !abort_now)
            pass_cnt <= pass_cnt + 16'd1;

         // The compare still counts on an aborting read ack.
         if (rd_miss) begin
            if (err_cnt != 16'hFFFF)
               err_cnt <= err_cnt + 16'd1;
            if (!err) begin
               err       <= 1'b1;
               fail_addr <= addr;
            end
         end
      end
   end

   assign busy        = (state != S_IDLE);
   assign rnd_init    = (state == S_INIT);
   assign rnd_save    = (state == S_SAVE);
   assign rnd_restore = (state == S_RESTORE);
   assign rnd_next    = (state == S_WSTEP) || (state == S_RSTEP);
   assign mem_req     = (state == S_WR) || (state == S_RD);
   assign mem_we      = (state == S_WR);
   assign mem_addr    = addr;
   assign mem_wdata   = rnd_in;

endmodule

// File: doc/memtest_seq.md
# memtest_seq

Pass sequencer for the memory tester. It drives the init, save, restore and next strobes of the LFSR random-vector generator (`rnd_vec_gen`), and runs repeated write-then-verify passes over an address range through a single-outstanding memory request port. Each pass writes pseudo-random words, rewinds the generator to the state saved at pass start, reads the words back and compares them. It sits between the tester's control/status registers and the SDRAM controller's client port.

## Interface
- `ADDR_W`, 24: memory word-address width.
- `DATA_W`, 16: data width; must equal the generator's `OUT_SIZE`.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle strobe; begins a run from IDLE.
- `stop` in 1: one-cycle strobe; requests an abort.
- `len` in ADDR_W: word count per pass; sampled on `start`.
- `seed` in 8: init-hold length select; sampled on `start`.
- `rnd_in` in DATA_W: generator output (`out`).
- `rnd_init`, `rnd_save`, `rnd_restore`, `rnd_next` out 1 each: generator strobes.
- `mem_req` out 1: request valid; held until acknowledged.
- `mem_we` out 1: 1 = write, 0 = read; valid while `mem_req` is high.
- `mem_addr` out ADDR_W: word address.
- `mem_wdata` out DATA_W: equals `rnd_in` combinationally.
- `mem_ack` in 1: request accepted and completed; for reads, `mem_rdata` is valid in the same cycle.
- `mem_rdata` in DATA_W: read data.
- `busy` out 1: high in any state other than IDLE.
- `pass_cnt` out 16: completed passes; wraps.
- `err_cnt` out 16: mismatched words; saturates at 0xFFFF.
- `err` out 1: sticky; set on the first mismatch.
- `fail_addr` out ADDR_W: address of the first mismatch.

## Operation
- States: IDLE, INIT, SAVE, WR, WSTEP, RESTORE, RD, RSTEP.
- **IDLE**
  - `start` with `len != 0`: latch `len` and `seed`, clear the counters, `err` and `fail_addr`, go to INIT.
  - `start` with `len == 0`: ignored.
- **INIT**
  - `rnd_init` is high for exactly `seed+1` consecutive cycles (1..256), then the FSM goes to SAVE.
  - The same seed always gives the same data sequence.
- **SAVE**
  - `rnd_save` is high for 1 cycle.
  - addr ← 0; go to WR.
- **WR**
  - `mem_req=1`, `mem_we=1`, `mem_addr`=addr, `mem_wdata`=`rnd_in`.
  - On `mem_ack`, go to WSTEP.
- **WSTEP**
  - `rnd_next` is high for 1 cycle; addr ← addr+1.
  - If addr was `len-1`, go to RESTORE; otherwise go to WR.
- **RESTORE**
  - `rnd_restore` is high for 1 cycle; addr ← 0; go to RD.
- **RD**
  - `mem_req=1`, `mem_we=0`.
  - On `mem_ack`, compare `mem_rdata` against `rnd_in` in that cycle.
  - On mismatch: increment `err_cnt` (saturating). If `err` is 0, set `err` and latch `fail_addr`.
  - Go to RSTEP.
- **RSTEP**
  - `rnd_next` is high for 1 cycle; addr ← addr+1.
  - If addr was `len-1`: increment `pass_cnt` and go to SAVE. The next pass continues the sequence, so its data differs from the previous pass.
  - Otherwise go to RD.
- **Stop**
  - `stop` sets a latched abort flag.
  - The abort is honoured only outside WR and RD, or in WR/RD on the `mem_ack` cycle. The next state is then IDLE, with no step strobe and no `pass_cnt` increment. An in-flight request is never dropped before `mem_ack`.
  - The compare on an aborting read ack is still performed.
  - `stop` in IDLE is ignored; the flag clears on entering IDLE.
- **Strobe exclusivity:** at most one `rnd_*` strobe is high in any cycle. `rnd_init` is never high outside INIT.
- `start` while `busy` is ignored.

## Timing
- All outputs except `mem_wdata` are decoded from registered state and counters (Moore); there is no combinational path from `mem_ack` to `mem_req`.
- Reset values:
  - state IDLE; `busy`, `mem_req`, `mem_we` and all strobes 0.
  - `mem_addr`, `pass_cnt`, `err_cnt`, `err`, `fail_addr` all 0.
- Reset asserted mid-run forces these values immediately, without waiting for a clock edge. An outstanding memory request is abandoned; the memory side must tolerate this.
- Generator update latency is one edge. After a WSTEP/RSTEP/RESTORE/INIT cycle, `rnd_in` is valid in the following cycle, which is the next WR/RD/SAVE cycle.
- With zero-wait memory (`mem_ack` in the first `mem_req` cycle), each word takes 2 cycles.
- First pass length = (`seed`+1) + 1 + 2·len + 1 + 2·len cycles, from the cycle after `start` to the cycle after the last RSTEP. Later passes omit the init term.
- `busy` rises the cycle after `start` and falls the cycle after the abort point.

## Test plan
- **Basic pass:** `len=4`, `seed=0`, zero-wait memory model. Required:
  - `mem_req` sequence is writes 0,1,2,3, one RESTORE cycle, then reads 0,1,2,3.
  - Read data equals written data; `err_cnt=0`.
  - `pass_cnt=1` exactly 20 cycles after `start`.
  - Pass-2 write data differs from pass-1 write data.
- **Error injection:** model flips bit 0 of addr 2 on read in pass 1. Required:
  - `err=1`, `err_cnt=1`, `fail_addr=2`.
  - Pass 2 runs; a second injected error at addr 3 gives `err_cnt=2` with `fail_addr` still 2.
- **Stop with delayed ack:** `stop` asserted in WR at addr 1 with ack delayed 5 cycles. Required:
  - `mem_req` is held 5 cycles, then IDLE the cycle after the ack.
  - `busy` falls; `pass_cnt=0`; no `rnd_next` is emitted after the ack.
- **Rejected start:** `len=0` with `start`. Required: `busy` stays 0 and all strobes stay 0; `start` while busy is ignored.
- **Async reset:** `rst_n` low mid-RD between clock edges. Required: all outputs read as reset values before the next edge. A following `start` with the same `seed` reproduces pass-1 data exactly.
- **Protocol checkers:**
  - Never two `rnd_*` strobes in one cycle.
  - `rnd_next` count per pass equals `2·len`.
  - `seed=255` gives 256 `rnd_init` cycles.
